// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared opcode constants and source-register usage decode for the load-use hazard unit.
package hazard_pkg;

  localparam int unsigned INS_W = 32;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

  function automatic logic uses_rs1(input logic [OPC_W-1:0] opcode);
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH: uses_rs1 = 1'b1;
      OP_LUI, OP_AUIPC, OP_JAL:                             uses_rs1 = 1'b0;
      default:                                              uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [OPC_W-1:0] opcode);
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      default:                   uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard bus: EX/ID pipeline view in, stall controls and perf count out.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) ();

  logic              ins_valid;
  logic [31:0]       ins;
  logic [REG_AW-1:0] rd;
  logic              memrd;
  logic              flush;
  logic              control;
  logic              PCWrite;
  logic              IFIDWrite;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output ins_valid, ins, rd, memrd, flush,
    input  control, PCWrite, IFIDWrite, stall_cnt
  );

  modport slave (
    input  ins_valid, ins, rd, memrd, flush,
    output control, PCWrite, IFIDWrite, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_unit_scoreboard.sv
// Per-register countdown of cycles a loaded value remains unforwardable; x0 never pends.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_idx_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              rs1_busy_c_o,
  output logic              rs2_busy_c_o
);

  localparam int unsigned    PW      = $clog2(LOAD_LAT + 1);
  localparam logic [PW-1:0]  SET_VAL = PW'(LOAD_LAT - 1);

  logic [PW-1:0] pend_q [NUM_REGS];
  logic [PW-1:0] pend_d [NUM_REGS];

  // New load restarts its entry; set takes priority over the decrement.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = '0;
      if (r != 0) begin
        if (set_en_i && (set_idx_i == REG_AW'(r))) begin
          pend_d[r] = SET_VAL;
        end else if (pend_q[r] != '0) begin
          pend_d[r] = pend_q[r] - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Load currently in EX counts as busy before it lands in the array.
  always_comb begin
    rs1_busy_c_o = (rs1_i != '0) &&
                   ((set_en_i && (set_idx_i == rs1_i)) || (pend_q[rs1_i] != '0));
    rs2_busy_c_o = (rs2_i != '0) &&
                   ((set_en_i && (set_idx_i == rs2_i)) || (pend_q[rs2_i] != '0));
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard detector for the ID stage: decode, stall combine, reset forcing, perf count.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scoreboard_unit_if.slave bus
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              use_rs1;
  logic              use_rs2;
  logic              set_en;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              stall_c;
  logic              unused_ins;

  always_comb begin
    opcode  = bus.ins[6:0];
    rs1     = REG_AW'(bus.ins[19:15]);
    rs2     = REG_AW'(bus.ins[24:20]);
    use_rs1 = uses_rs1(opcode);
    use_rs2 = uses_rs2(opcode);
    set_en  = bus.memrd && (bus.rd != '0);
  end

  assign unused_ins = ^{bus.ins[31:25], bus.ins[14:7]};

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en_i     (set_en),
    .set_idx_i    (bus.rd),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .rs1_busy_c_o (rs1_busy),
    .rs2_busy_c_o (rs2_busy)
  );

  // Held reset and a flushed ID both mask the stall.
  assign stall_c = rst_n && bus.ins_valid && !bus.flush &&
                   ((use_rs1 && rs1_busy) || (use_rs2 && rs2_busy));

  assign bus.control   = stall_c;
  assign bus.PCWrite   = !stall_c;
  assign bus.IFIDWrite = !stall_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.stall_cnt = cnt_q;
`else
  assign bus.stall_cnt = CNT_W'(0);
`endif

endmodule
